// File: rtl/bsg_dfi_fifo_to_mem.sv
// Memory-side consumer for the DFI-to-FIFO bridge. Pops DDR3 commands and
// write data, tracks the open row per bank, expands each RD/WR burst into four
// single-beat memory requests and buffers read responses for the bridge.
module bsg_dfi_fifo_to_mem #(
  parameter int unsigned dq_data_width_p = 32,
  parameter int unsigned rd_buf_els_p    = 8
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  input  logic                                          cmd_v_i,
  input  logic [25:0]                                   cmd_data_i,
  output logic                                          cmd_yumi_o,
  input  logic                                          wr_v_i,
  input  logic [2*dq_data_width_p+dq_data_width_p/4-1:0] wr_data_i,
  output logic                                          wr_yumi_o,
  output logic                                          mem_v_o,
  output logic                                          mem_w_o,
  output logic [27:0]                                   mem_addr_o,
  output logic [2*dq_data_width_p-1:0]                  mem_data_o,
  output logic [dq_data_width_p/4-1:0]                  mem_mask_o,
  input  logic                                          mem_ready_i,
  input  logic                                          mem_v_i,
  input  logic [2*dq_data_width_p-1:0]                  mem_data_i,
  output logic                                          rd_v_o,
  output logic [2*dq_data_width_p-1:0]                  rd_data_o,
  input  logic                                          rd_yumi_i,
  output logic                                          err_o
);

  localparam int unsigned DataW = 2 * dq_data_width_p;
  localparam int unsigned MaskW = dq_data_width_p / 4;
  localparam int unsigned PtrW  = (rd_buf_els_p > 1) ? $clog2(rd_buf_els_p) : 1;
  localparam int unsigned CntW  = $clog2(rd_buf_els_p + 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e state_q, state_d;

  // Command fields
  logic [2:0]  c_bank;
  logic [15:0] c_addr;
  logic [2:0]  c_op;
  logic        c_cke, c_rstn;
  assign c_bank = cmd_data_i[25:23];
  assign c_addr = cmd_data_i[22:7];
  assign c_cke  = cmd_data_i[6];
  assign c_op   = cmd_data_i[4:2];
  assign c_rstn = cmd_data_i[1];

  // cs_n, odt and the burst-offset address bits carry no meaning here
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{cmd_data_i[5], cmd_data_i[0], cmd_data_i[9:7]};

  logic [7:0]       open_q;
  logic [15:0]      row_q [8];
  logic [2:0]       bank_q;
  logic [15:0]      brow_q;
  logic [6:0]       col_q;
  logic [1:0]       beat_q;
  logic             err_q;
  logic [CntW-1:0]  cnt_q, outst_q;
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [DataW-1:0] buf_q [rd_buf_els_p];

  logic act, pre_one, close_all, burst_start, err_set;
  logic credit, req_fire, rd_req, enq, deq;
  logic [CntW:0] used;

  assign used   = {1'b0, cnt_q} + {1'b0, outst_q};
  assign credit = used < (CntW + 1)'(rd_buf_els_p);

  // Command decode, burst sequencing and handshake outputs
  always_comb begin
    state_d     = state_q;
    cmd_yumi_o  = 1'b0;
    wr_yumi_o   = 1'b0;
    mem_v_o     = 1'b0;
    mem_w_o     = 1'b0;
    act         = 1'b0;
    pre_one     = 1'b0;
    close_all   = 1'b0;
    burst_start = 1'b0;
    err_set     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_v_i) begin
          cmd_yumi_o = 1'b1;
          if (!c_rstn) begin
            close_all = 1'b1;
          end else if (c_cke) begin
            unique case (c_op)
              3'b011: begin
                act     = 1'b1;
                err_set = open_q[c_bank];
              end
              3'b010: begin
                close_all = c_addr[10];
                pre_one   = ~c_addr[10];
              end
              3'b001: err_set = |open_q;
              3'b100, 3'b101: begin
                burst_start = 1'b1;
                err_set     = ~open_q[c_bank];
                state_d     = c_op[0] ? StRead : StWrite;
              end
              default: ;
            endcase
          end
        end
      end
      StWrite: begin
        mem_v_o   = wr_v_i;
        mem_w_o   = 1'b1;
        wr_yumi_o = wr_v_i & mem_ready_i;
        if (wr_yumi_o && beat_q == 2'd3) state_d = StIdle;
      end
      StRead: begin
        mem_v_o = credit;
        if (credit && mem_ready_i && beat_q == 2'd3) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (reset_i) begin
      cmd_yumi_o = 1'b0;
      wr_yumi_o  = 1'b0;
      mem_v_o    = 1'b0;
    end
  end

  assign req_fire   = mem_v_o & mem_ready_i;
  assign rd_req     = req_fire & ~mem_w_o;
  assign mem_addr_o = {bank_q, brow_q, col_q, beat_q};
  assign mem_data_o = wr_data_i[DataW+MaskW-1:MaskW];
  assign mem_mask_o = ~wr_data_i[MaskW-1:0];
  assign err_o      = err_q;

  // FSM state plus the latched burst address
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      bank_q  <= '0;
      brow_q  <= '0;
      col_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (burst_start) begin
        bank_q <= c_bank;
        brow_q <= row_q[c_bank];
        col_q  <= c_addr[9:3];
        beat_q <= '0;
      end else if (req_fire) begin
        beat_q <= beat_q + 2'd1;
      end
    end
  end

  // Per-bank open flag and row; an ACT to an open bank still takes the new row
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      open_q <= '0;
      for (int i = 0; i < 8; i++) row_q[i] <= '0;
    end else if (close_all) begin
      open_q <= '0;
    end else if (pre_one) begin
      open_q[c_bank] <= 1'b0;
    end else if (act) begin
      open_q[c_bank] <= 1'b1;
      row_q[c_bank]  <= c_addr;
    end
  end

  // Sticky protocol-violation flag
  always_ff @(posedge clk_i) begin
    if (reset_i) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(rd_buf_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full-and-popping still accepts a beat since the slot frees this cycle
  assign deq    = rd_yumi_i & rd_v_o;
  assign enq    = mem_v_i & ((cnt_q != CntW'(rd_buf_els_p)) | deq);
  assign rd_v_o = (cnt_q != '0);
  assign rd_data_o = buf_q[rptr_q];

  // Read buffer pointers, occupancy and outstanding-request credit
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      outst_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      if (enq) wptr_q <= ptr_inc(wptr_q);
      if (deq) rptr_q <= ptr_inc(rptr_q);
      if (enq && !deq) cnt_q <= cnt_q + 1'b1;
      else if (deq && !enq) cnt_q <= cnt_q - 1'b1;
      if (rd_req && !mem_v_i) outst_q <= outst_q + 1'b1;
      else if (mem_v_i && !rd_req && outst_q != '0) outst_q <= outst_q - 1'b1;
    end
  end

  // Read buffer storage
  always_ff @(posedge clk_i) begin
    if (enq) buf_q[wptr_q] <= mem_data_i;
  end

endmodule

// File: doc/bsg_dfi_fifo_to_mem.md
# bsg_dfi_fifo_to_mem

Memory-side consumer for the DFI-to-FIFO bridge: pops the DDR command and write-data FIFOs, decodes DDR3 commands, and tracks the open row per bank. It turns each RD/WR burst into four single-beat requests on a simple in-order memory port, and returns read beats through an internal buffer to the read-data FIFO input of the bridge. Runs entirely in the FIFO clock domain; it replaces a physical DRAM in emulation and test systems.

## Interface
- dq_data_width_p, "inv": DQ width. One beat is 2*dq_data_width_p data bits plus dq_data_width_p/4 mask bits.
- rd_buf_els_p, 8: read-return buffer depth, ≥2.
- clk_i  in  1  FIFO-domain clock; single clock; all state on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- cmd_v_i  in  1  command FIFO valid.
- cmd_data_i  in  26  {bank[25:23], addr[22:7], cke[6], cs_n[5], ras_n[4], cas_n[3], we_n[2], reset_n[1], odt[0]}.
- cmd_yumi_o  out  1  command pop.
- wr_v_i  in  1  write-data FIFO valid.
- wr_data_i  in  2*dq+dq/4  {data, mask}; mask bit 1 = byte not written.
- wr_yumi_o  out  1  write-data pop.
- mem_v_o  out  1  memory request valid.
- mem_w_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  28  {bank[2:0], row[15:0], col[9:3], beat[1:0]}.
- mem_data_o  out  2*dq  write data.
- mem_mask_o  out  dq/4  byte enable = ~mask.
- mem_ready_i  in  1  request accepted when mem_v_o & mem_ready_i.
- mem_v_i  in  1  read response valid; in order; no backpressure.
- mem_data_i  in  2*dq  read response data.
- rd_v_o  out  1  read buffer non-empty.
- rd_data_o  out  2*dq  buffer head.
- rd_yumi_i  in  1  pop buffer head; asserted only when rd_v_o is high.
- err_o  out  1  sticky protocol-violation flag.

## Operation
- States: IDLE, WRITE, READ.
- In IDLE with cmd_v_i high, the command is decoded from {ras_n,cas_n,we_n}. cmd_yumi_o is asserted in the same cycle for every command.
  - 011 ACT: row[bank] ← addr, open[bank] ← 1. ACT to an already-open bank sets err_o; the row is still overwritten.
  - 010 PRE: if addr[10] = 1, all banks close; otherwise only that bank closes.
  - 001 REF: no-op. Sets err_o if any bank is open.
  - 000 MRS, 110 ZQ, 111 NOP: no-op.
  - 100 WR: latch bank, row[bank] and addr[9:3]; beat ← 0; go to WRITE. Sets err_o if the bank is closed; the burst still executes using the stale row.
  - 101 RD: same as WR, but go to READ.
  - cke = 0 or reset_n = 0 overrides decode. reset_n = 0 closes all banks; cke = 0 is a no-op.
- In WRITE and READ, cmd_yumi_o = 0; the command FIFO is not popped mid-burst.
- WRITE:
  - mem_v_o = wr_v_i; mem_w_o = 1.
  - wr_yumi_o = wr_v_i & mem_ready_i.
  - On each handshake beat increments. After beat 3 is accepted, return to IDLE.
- READ:
  - Credit condition: occupancy + outstanding < rd_buf_els_p.
  - mem_v_o = credit available; mem_w_o = 0.
  - outstanding increments on request handshake and decrements on mem_v_i; both in the same cycle leave it unchanged.
  - After the beat-3 request is accepted, return to IDLE. Responses may still be outstanding.
- mem_addr_o = {latched bank, latched row, latched col, beat}. addr[2:0] is ignored; bursts are aligned.
- The read buffer is a FIFO. It enqueues on mem_v_i and dequeues on rd_yumi_i; simultaneous enqueue and dequeue at full or empty is legal.
- err_o clears only on reset.

## Timing
- During and after reset: state IDLE, all banks closed, beat/outstanding/occupancy = 0, err_o = 0, rd_v_o = 0, mem_v_o = 0. All handshake outputs are 0 while reset_i is high.
- Handshake outputs (cmd_yumi_o, wr_yumi_o, mem_v_o) are combinational from state and inputs. No combinational path from mem_v_i to rd_v_o.
- Non-burst command: consumed in 1 cycle; back-to-back commands accepted every cycle.
- WR/RD: 1 cycle to consume the command, plus at least 4 cycles for the burst. Minimum cmd-to-cmd spacing is 5 cycles.
- Read data: rd_v_o rises the cycle after mem_v_i.
- mem_v_i is accepted in any state. The buffer can never overflow because of the credit rule.
- err_o rises the cycle after the offending command pops.
- A reset mid-burst abandons the burst and discards buffered and outstanding data. Responses arriving after reset are the environment's responsibility.

## Test plan
- **ACT, WR, RD round trip:** ACT bank 2 row 0x1234; WR col 0x40 with data D0..D3, mask 0; RD col 0x40 → mem_addr_o = {2,0x1234,0x08,0..3}; rd_data_o returns D0..D3 in order; err_o = 0.
- **Write stall:** wr_v_i low for 3 cycles mid-burst → mem_v_o low and beat held; mem_ready_i low → wr_yumi_o low; exactly 4 pops in total.
- **Read credit limit:** rd_buf_els_p = 2, rd_yumi_i held low → only 2 requests issue; pop 1 beat → 1 further request issues; all 4 beats eventually delivered.
- **Violations:**
  - RD to a closed bank → err_o = 1 the next cycle and stays high.
  - ACT to an open bank → err_o = 1.
  - REF with bank 5 open → err_o = 1.
  - PRE with addr[10] = 1, then REF → err_o stays 0.
- **Partial write:** byte mask 0x0F → mem_mask_o = 0xF0 (for dq_data_width_p = 32).
- **Reset mid-read:** 2 beats buffered, reset pulsed → rd_v_o = 0, IDLE; next ACT accepted in 1 cycle.
